// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 14;
  localparam int ARB_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  typedef struct packed {
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant; last_grant=1 means m1 won last.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the master that did not win last time takes it.
  assign gnt[0] = req[0] & (~req[1] | last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter/sequencer for the banked single-port sync RAM.
// Define RAM_ARB_PERF_EN to add per-master grant and tie-cycle counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [15:0]           perf_m0_cnt,
  output logic [15:0]           perf_m1_cnt,
  output logic [15:0]           perf_conflict_cnt
`endif
);

  state_t     state, state_nx;
  logic       last_grant;
  logic [1:0] req, arb_gnt, gnt;
  req_t       req_sel, lat;
  logic       lat_id;
  logic       drive;

  assign req = {m1_req, m0_req};

  rr_arbiter_2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (arb_gnt)
  );

  assign gnt    = (state == IDLE) ? arb_gnt : 2'b00;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    req_sel.we    = gnt[1] ? m1_we    : m0_we;
    req_sel.addr  = gnt[1] ? m1_addr  : m0_addr;
    req_sel.wdata = gnt[1] ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_addr = '0;
    drive    = 1'b0;
    case (state)
      IDLE: if (|gnt) state_nx = ACCESS;
      ACCESS: begin
        ram_cs   = 1'b1;
        ram_addr = lat.addr;
        ram_we   = lat.we;
        ram_oe   = ~lat.we;
        drive    = lat.we;
        state_nx = lat.we ? IDLE : RDATA;
      end
      RDATA: begin
        // RAM drives the bus with the word it captured at the end of ACCESS.
        ram_cs   = 1'b1;
        ram_addr = lat.addr;
        ram_oe   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ram_data = drive ? lat.wdata : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat        <= '0;
      lat_id     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (|gnt) begin
        lat        <= req_sel;
        lat_id     <= gnt[1];
        last_grant <= gnt[1];
      end
      if (state == RDATA) begin
        if (lat_id) begin
          m1_rdata  <= ram_data;
          m1_rvalid <= 1'b1;
        end else begin
          m0_rdata  <= ram_data;
          m0_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_m0_cnt       <= '0;
      perf_m1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (gnt[0]) perf_m0_cnt <= perf_m0_cnt + 16'd1;
      if (gnt[1]) perf_m1_cnt <= perf_m1_cnt + 16'd1;
      if (state == IDLE && m0_req && m1_req)
        perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grant order, latency and memory contents.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [13:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_cs, ram_we, ram_oe;
`ifdef RAM_ARB_PERF_EN
  logic [15:0] perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
`ifdef RAM_ARB_PERF_EN
    , .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port sync RAM: captures on every selected edge, drives while cs&&oe&&!we.
  logic [15:0] mem [0:16383];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 16'hzzzz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int m, input logic r, input logic we,
                         input logic [13:0] a, input logic [15:0] d);
    if (m == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic do_reset();
    set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  // Hold a request until granted (bounded); returns in the ACCESS cycle.
  task automatic issue(input int m, input logic we, input logic [13:0] a,
                       input logic [15:0] d, output bit ok);
    ok = 1'b0;
    set_req(m, 1, we, a, d);
    for (int i = 0; i < 16 && !ok; i++) begin
      #1;
      ok = (m == 0) ? m0_gnt : m1_gnt;
      tick();
    end
    set_req(m, 0, we, a, d);
  endtask

  task automatic test_reset();
    set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
    rst_n = 1'b0; tick(); tick();
    n_chk++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0)
      $display("FAIL reset_hs: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    else n_pass++;
    n_chk++;
    if ({m0_rdata, m1_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
    else n_pass++;
    n_chk++;
    if ({ram_cs, ram_we, ram_oe, ram_addr} !== 17'h0)
      $display("FAIL reset_ram: got %h want 0", {ram_cs, ram_we, ram_oe, ram_addr});
    else n_pass++;
`ifdef RAM_ARB_PERF_EN
    n_chk++;
    if ({perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt} !== 48'h0)
      $display("FAIL reset_perf: got %h want 0", {perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt});
    else n_pass++;
`endif
    rst_n = 1'b1; tick();
  endtask

  task automatic test_write_read();
    bit ok;
    issue(0, 1, 14'h0005, 16'hBEEF, ok);
    n_chk++;
    if (!ok) $display("FAIL wr_gnt: got 0 want 1"); else n_pass++;
    n_chk++;
    if ({ram_cs, ram_we, ram_oe, ram_addr, ram_data} !== {3'b110, 14'h0005, 16'hBEEF})
      $display("FAIL wr_access: got %b %h %h want 110 0005 beef",
               {ram_cs, ram_we, ram_oe}, ram_addr, ram_data);
    else n_pass++;
    tick();
    n_chk++;
    if (mem[5] !== 16'hBEEF) $display("FAIL wr_mem: got %h want beef", mem[5]); else n_pass++;
    issue(0, 0, 14'h0005, 16'h0, ok);
    n_chk++;
    if (!ok || {ram_we, ram_oe} !== 2'b01)
      $display("FAIL rd_access: got ok=%0d we/oe=%b want 1 01", ok, {ram_we, ram_oe});
    else n_pass++;
    tick();
    n_chk++;
    if (m0_rvalid !== 1'b0) $display("FAIL rd_early: got %b want 0", m0_rvalid); else n_pass++;
    tick();
    n_chk++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 16'hBEEF})
      $display("FAIL rd_data: got %b %h want 1 beef", m0_rvalid, m0_rdata);
    else n_pass++;
    n_chk++;
    if ({m1_rvalid, m1_gnt, m1_rdata} !== 18'h0)
      $display("FAIL m1_quiet: got %b %b %h want 0 0 0000", m1_rvalid, m1_gnt, m1_rdata);
    else n_pass++;
    tick();
    n_chk++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 16'hBEEF})
      $display("FAIL rd_hold: got %b %h want 0 beef", m0_rvalid, m0_rdata);
    else n_pass++;
  endtask

  task automatic test_bank_cross();
    bit ok;
    issue(1, 1, 14'h3FFF, 16'h1234, ok);
    n_chk++;
    if (ram_addr !== 14'h3FFF) $display("FAIL bc_addr: got %h want 3fff", ram_addr); else n_pass++;
    tick();
    issue(1, 1, 14'h0000, 16'h5678, ok); tick();
    issue(1, 0, 14'h3FFF, 16'h0, ok); tick(); tick();
    n_chk++;
    if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 16'h1234, 1'b0})
      $display("FAIL bc_rd_top: got %b %h %b want 1 1234 0", m1_rvalid, m1_rdata, m0_rvalid);
    else n_pass++;
    issue(1, 0, 14'h0000, 16'h0, ok); tick(); tick();
    n_chk++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 16'h5678})
      $display("FAIL bc_rd_bot: got %b %h want 1 5678", m1_rvalid, m1_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_read_then_write();
    set_req(0, 1, 0, 14'h0005, 16'h0); #1;
    n_chk++;
    if (m0_gnt !== 1'b1) $display("FAIL rtw_gnt0: got %b want 1", m0_gnt); else n_pass++;
    tick();
    set_req(0, 0, 0, 14'h0005, 16'h0);
    set_req(1, 1, 1, 14'h0006, 16'hCAFE); #1;
    n_chk++;
    if (m1_gnt !== 1'b0) $display("FAIL rtw_busy: got %b want 0", m1_gnt); else n_pass++;
    tick(); tick(); #1;
    n_chk++;
    if ({m0_rvalid, m0_rdata, m1_gnt} !== {1'b1, 16'hBEEF, 1'b1})
      $display("FAIL rtw_overlap: got %b %h %b want 1 beef 1", m0_rvalid, m0_rdata, m1_gnt);
    else n_pass++;
    tick();
    set_req(1, 0, 1, 14'h0006, 16'hCAFE);
    n_chk++;
    if ({ram_we, ram_oe} !== 2'b10 || mem[6] === 16'hCAFE)
      $display("FAIL rtw_wcycle: got we/oe=%b mem=%h want 10 not-cafe", {ram_we, ram_oe}, mem[6]);
    else n_pass++;
    tick();
    n_chk++;
    if (mem[6] !== 16'hCAFE) $display("FAIL rtw_land: got %h want cafe", mem[6]); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    issue(0, 0, 14'h0005, 16'h0, ok); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_chk++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_cs, ram_we, ram_oe} !== 7'h0)
      $display("FAIL rmr_ctl: got %b want 0000000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_cs, ram_we, ram_oe});
    else n_pass++;
    n_chk++;
    if ({m0_rdata, m1_rdata, ram_addr} !== 46'h0)
      $display("FAIL rmr_data: got %h %h %h want 0", m0_rdata, m1_rdata, ram_addr);
    else n_pass++;
    tick();
    n_chk++;
    if (m0_rvalid !== 1'b0) $display("FAIL rmr_norv: got %b want 0", m0_rvalid); else n_pass++;
    issue(1, 0, 14'h3FFF, 16'h0, ok);
    n_chk++;
    if (!ok) $display("FAIL rmr_regnt: got 0 want 1"); else n_pass++;
    tick(); tick();
    n_chk++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 16'h1234})
      $display("FAIL rmr_rd: got %b %h want 1 1234", m1_rvalid, m1_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_drop_req();
    bit ok;
    int bad = 0;
    issue(1, 1, 14'h0010, 16'h1111, ok);
    set_req(0, 1, 0, 14'h0007, 16'h0); #1;
    n_chk++;
    if (m0_gnt !== 1'b0) $display("FAIL drop_gnt: got %b want 0", m0_gnt); else n_pass++;
    tick();
    set_req(0, 0, 0, 14'h0007, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m0_gnt || ram_cs || m0_rvalid) bad++;
      tick();
    end
    n_chk++;
    if (bad !== 0) $display("FAIL drop_quiet: got %0d active cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_alternate();
    int ng = 0;
    logic [1:0] g;
    do_reset();
    set_req(0, 1, 1, 14'h0200, 16'hA0A0);
    set_req(1, 1, 1, 14'h0201, 16'hB1B1);
    for (int i = 0; i < 60 && ng < 10; i++) begin
      #1;
      g = {m1_gnt, m0_gnt};
      if (g != 2'b00) begin
        n_chk++;
        if (g !== ((ng % 2 == 1) ? 2'b10 : 2'b01))
          $display("FAIL alt_order[%0d]: got %b want %b", ng, g, (ng % 2 == 1) ? 2'b10 : 2'b01);
        else n_pass++;
        ng++;
      end
      tick();
    end
    set_req(0, 0, 1, 14'h0200, 16'hA0A0);
    set_req(1, 0, 1, 14'h0201, 16'hB1B1);
    n_chk++;
    if (ng !== 10) $display("FAIL alt_count: got %0d want 10", ng); else n_pass++;
`ifdef RAM_ARB_PERF_EN
    n_chk++;
    if (perf_m0_cnt !== 16'd5 || perf_m1_cnt !== 16'd5 || perf_conflict_cnt == 16'd0)
      $display("FAIL alt_perf: got %0d %0d %0d want 5 5 >0",
               perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt);
    else n_pass++;
`endif
    tick(); tick();
  endtask

  // Model: the arbiter is free again 2 cycles after a write grant, 3 after a
  // read; read data appears 3 cycles after its grant; ties go to the other master.
  task automatic test_random();
    int free_at = 0, lw = 1, w, g0 = 0, g1 = 0, conf = 0;
    bit p[2];
    logic pwe[2];
    logic [5:0] pi[2];
    logic [15:0] pd[2];
    bit rknown[64];
    logic [15:0] rmem[64];
    int ev_c[$]; int ev_m[$]; logic [15:0] ev_d[$]; bit ev_k[$];
    bit e0, e1, ek, clash = 0;
    logic [15:0] ed;
    for (int i = 0; i < 64; i++) begin rknown[i] = 0; rmem[i] = '0; end
    for (int m = 0; m < 2; m++) begin p[m] = 0; pwe[m] = 0; pi[m] = '0; pd[m] = '0; end
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e0 = 0; e1 = 0; ek = 0; ed = '0;
      if (ev_c.size() > 0 && ev_c[0] == c) begin
        e0 = (ev_m[0] == 0); e1 = (ev_m[0] == 1); ek = ev_k[0]; ed = ev_d[0];
        void'(ev_c.pop_front()); void'(ev_m.pop_front());
        void'(ev_d.pop_front()); void'(ev_k.pop_front());
      end
      n_chk++;
      if ({m1_rvalid, m0_rvalid} !== {e1, e0})
        $display("FAIL rnd_rvalid@%0d: got %b want %b", c, {m1_rvalid, m0_rvalid}, {e1, e0});
      else n_pass++;
      if (ek) begin
        n_chk++;
        if ((e0 ? m0_rdata : m1_rdata) !== ed)
          $display("FAIL rnd_rdata@%0d: got %h want %h", c, e0 ? m0_rdata : m1_rdata, ed);
        else n_pass++;
      end
      if (ram_we && ram_oe) clash = 1;
      for (int m = 0; m < 2; m++) begin
        if (!p[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            p[m] = 1; pwe[m] = 1'($urandom_range(0, 1));
            pi[m] = 6'($urandom_range(0, 63)); pd[m] = 16'($urandom);
          end
        end else if ($urandom_range(0, 9) == 0) p[m] = 0;
        set_req(m, p[m], pwe[m], {8'h04, pi[m]}, pd[m]);
      end
      #1;
      w = -1;
      if (c >= free_at) begin
        if (p[0] && p[1]) begin w = 1 - lw; conf++; end
        else if (p[0]) w = 0;
        else if (p[1]) w = 1;
      end
      n_chk++;
      if ({m1_gnt, m0_gnt} !== {w == 1, w == 0})
        $display("FAIL rnd_gnt@%0d: got %b want %b", c, {m1_gnt, m0_gnt}, {w == 1, w == 0});
      else n_pass++;
      if (w >= 0) begin
        if (pwe[w]) begin
          rmem[pi[w]] = pd[w]; rknown[pi[w]] = 1; free_at = c + 2;
        end else begin
          ev_c.push_back(c + 3); ev_m.push_back(w);
          ev_d.push_back(rmem[pi[w]]); ev_k.push_back(rknown[pi[w]]);
          free_at = c + 3;
        end
        lw = w;
        if (w == 0) g0++; else g1++;
        p[w] = 0;
      end
      tick();
    end
    n_chk++;
    if (clash) $display("FAIL rnd_bus: got we&&oe asserted want never"); else n_pass++;
`ifdef RAM_ARB_PERF_EN
    n_chk++;
    if (perf_m0_cnt !== 16'(g0) || perf_m1_cnt !== 16'(g1) || perf_conflict_cnt !== 16'(conf))
      $display("FAIL rnd_perf: got %0d %0d %0d want %0d %0d %0d",
               perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt, g0, g1, conf);
    else n_pass++;
`endif
    set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
    test_reset();
    test_write_read();
    test_bank_cross();
    test_read_then_write();
    test_reset_mid_read();
    test_drop_req();
    test_alternate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
